plot_port_arbiter: RTL and testbench
====================================

// Module: plot_port_arbiter
// PURPOSE
//  Shares the single vga_adapter write port (x, y, colour, plot) between two pixel sources:
//  - req0: the box drawer.
//  - req1: a frame clear/erase engine.
//  Arbitration is round-robin with burst locking: an owner keeps the port until it sends its last pixel.
//  Off-screen pixels are dropped.
//  The block sits between the star-finder drawing engines and vga_adapter in find_stars.
// PARAMETERS
//  xSz      8    x coordinate width
//  ySz      7    y coordinate width
//  colSz    3    colour width
//  XMAX     160  screen width; a pixel is plotted only if x < XMAX
//  YMAX     120  screen height; a pixel is plotted only if y < YMAX
//  TIMEOUT  255  idle cycles an owner may hold the port with valid low before it is revoked (1..255)
// PORTS
//  clk          in   1      system clock (CLOCK_50)
//  reset        in   1      asynchronous, active-high reset
//  req0_valid   in   1      requester 0 presents a pixel
//  req0_x       in   xSz    requester 0 pixel x
//  req0_y       in   ySz    requester 0 pixel y
//  req0_col     in   colSz  requester 0 pixel colour
//  req0_last    in   1      current pixel is the final pixel of req0's burst
//  req0_ready   out  1      req0 pixel accepted this cycle when valid & ready
//  req1_*       (same six signals for requester 1)
//  x_out        out  xSz    to vga_adapter x
//  y_out        out  ySz    to vga_adapter y
//  col_out      out  colSz  to vga_adapter colour
//  plot_out     out  1      to vga_adapter plot
//  grant        out  2      one-hot current owner; 00 = idle
//  clip_pulse   out  1      one-cycle pulse: an accepted pixel was dropped as off-screen
//  timeout_pulse out 1      one-cycle pulse: an owner was revoked by the watchdog
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; round-robin pointer = 0 (req0 favoured); watchdog = 0.
//  - FSM states: IDLE, OWN0, OWN1.
//  - IDLE:
//    - Only req0 valid -> OWN0. Only req1 valid -> OWN1.
//    - Both valid -> the requester the pointer favours wins.
//    - ready is 0 in IDLE. The first pixel can be accepted one cycle after the request.
//  - OWNn:
//    - reqn_ready = 1; the other requester's ready = 0.
//    - A pixel is accepted on valid & ready.
//    - Accepting a pixel with last = 1 -> IDLE, and the pointer moves to favour the other requester.
//  - Watchdog:
//    - Counts consecutive OWNn cycles with reqn_valid = 0; it clears on any accepted pixel.
//    - When it reaches TIMEOUT: go to IDLE, pulse timeout_pulse, flip the pointer.
//    - No pixel is accepted in that cycle.
//  - Output pipeline, 1-cycle latency:
//    - x_out, y_out and col_out register the accepted pixel.
//    - plot_out = 1 the cycle after an accept, but only if x < XMAX and y < YMAX.
//    - Otherwise plot_out = 0, clip_pulse = 1, and x_out, y_out and col_out keep their previous values.
//    - Cycles with no accept: plot_out = 0; the coordinate registers hold.
//  - Back-to-back accepts give a continuous stream: one pixel per clock.
//  - grant mirrors the state: 01 = OWN0, 10 = OWN1, 00 = IDLE.
//  - Valid dropping mid-burst does not release ownership; only last or the watchdog do.
//  - Reset mid-burst:
//    - Immediately forces IDLE and plot_out = 0. A pixel accepted in the reset cycle is lost.
//    - Requesters must restart their bursts.
//  - Inputs are sampled only when ready = 1; requesters hold their data stable while valid & !ready.
// TESTING
//  - Single burst: req0 sends 3 pixels (10,5),(11,5),(12,5), last on the 3rd.
//    -> grant=01 one cycle after valid; plot_out high 3 consecutive cycles with matching x/y/col; then grant=00.
//  - Contention: req0 and req1 are valid in the same IDLE cycle after reset -> req0 wins.
//    After req0's last pixel, req1 is granted even though req0 re-requests.
//  - Clipping: req1 pixel (160,10) then (159,119).
//    -> first: clip_pulse=1, plot_out=0; second: plot_out=1 with x_out=159, y_out=119.
//  - Watchdog (TIMEOUT=4): req0 granted, sends 1 non-last pixel, then holds valid low.
//    -> after 4 idle owner cycles timeout_pulse=1, grant=00; a pending req1 is granted next.
//  - Mid-burst reset: assert reset during req1's 2nd pixel -> outputs 0 and grant=00 at once.
//    After release, req0 wins a tie because the pointer is reset.
//  - Stall: req0 owner toggles valid 1,0,1 with last on the 3rd cycle
//    -> exactly 2 plot_out pulses, no ownership loss.

Source files
------------

// File: rtl/plot_port_arbiter.sv
// Round-robin, burst-locked arbiter sharing the vga_adapter write port
// between the box drawer (req0) and the frame clear engine (req1).
module plot_port_arbiter #(
  parameter int xSz     = 8,
  parameter int ySz     = 7,
  parameter int colSz   = 3,
  parameter int XMAX    = 160,
  parameter int YMAX    = 120,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [xSz-1:0]   req0_x,
  input  logic [ySz-1:0]   req0_y,
  input  logic [colSz-1:0] req0_col,
  input  logic             req0_last,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [xSz-1:0]   req1_x,
  input  logic [ySz-1:0]   req1_y,
  input  logic [colSz-1:0] req1_col,
  input  logic             req1_last,
  output logic             req1_ready,
  output logic [xSz-1:0]   x_out,
  output logic [ySz-1:0]   y_out,
  output logic [colSz-1:0] col_out,
  output logic             plot_out,
  output logic [1:0]       grant,
  output logic             clip_pulse,
  output logic             timeout_pulse
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [xSz:0] XLIM    = (xSz+1)'(XMAX);
  localparam logic [ySz:0] YLIM    = (ySz+1)'(YMAX);
  localparam logic [7:0]   WD_LAST = 8'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [7:0]       wd_q, wd_d;
  logic [xSz-1:0]   x_q, x_d;
  logic [ySz-1:0]   y_q, y_d;
  logic [colSz-1:0] col_q, col_d;
  logic             plot_q, plot_d;
  logic             clip_q, clip_d;
  logic             to_q, to_d;

  logic             acc0, acc1, acc;
  logic [xSz-1:0]   px;
  logic [ySz-1:0]   py;
  logic [colSz-1:0] pcol;
  logic             plast;
  logic             on_screen;

  assign acc0 = (state_q == OWN0) && req0_valid;
  assign acc1 = (state_q == OWN1) && req1_valid;
  assign acc  = acc0 || acc1;

  assign px    = acc1 ? req1_x    : req0_x;
  assign py    = acc1 ? req1_y    : req0_y;
  assign pcol  = acc1 ? req1_col  : req0_col;
  assign plast = acc1 ? req1_last : req0_last;

  assign on_screen = ({1'b0, px} < XLIM) && ({1'b0, py} < YLIM);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wd_d    = wd_q;
    x_d     = x_q;
    y_d     = y_q;
    col_d   = col_q;
    plot_d  = 1'b0;
    clip_d  = 1'b0;
    to_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        wd_d = 8'd0;
        if (req0_valid && (!req1_valid || !ptr_q))
          state_d = OWN0;
        else if (req1_valid)
          state_d = OWN1;
      end
      OWN0, OWN1: begin
        if (acc) begin
          wd_d = 8'd0;
          if (plast) begin
            state_d = IDLE;
            ptr_d   = (state_q == OWN0);
          end
        end else if (wd_q == WD_LAST) begin
          // watchdog revokes a stalled owner and hands priority over
          state_d = IDLE;
          ptr_d   = (state_q == OWN0);
          to_d    = 1'b1;
          wd_d    = 8'd0;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (acc) begin
      if (on_screen) begin
        x_d    = px;
        y_d    = py;
        col_d  = pcol;
        plot_d = 1'b1;
      end else begin
        clip_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      wd_q    <= 8'd0;
      x_q     <= '0;
      y_q     <= '0;
      col_q   <= '0;
      plot_q  <= 1'b0;
      clip_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
      x_q     <= x_d;
      y_q     <= y_d;
      col_q   <= col_d;
      plot_q  <= plot_d;
      clip_q  <= clip_d;
      to_q    <= to_d;
    end
  end

  assign req0_ready    = (state_q == OWN0);
  assign req1_ready    = (state_q == OWN1);
  assign grant         = {state_q == OWN1, state_q == OWN0};
  assign x_out         = x_q;
  assign y_out         = y_q;
  assign col_out       = col_q;
  assign plot_out      = plot_q;
  assign clip_pulse    = clip_q;
  assign timeout_pulse = to_q;

endmodule

// File: tb/tb_plot_port_arbiter.sv
// Directed bench for plot_port_arbiter; expected pixels queued in a
// scoreboard when driven, popped when plot_out fires.
module tb_plot_port_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req0_last, req0_ready;
  logic [7:0] req0_x;
  logic [6:0] req0_y;
  logic [2:0] req0_col;
  logic       req1_valid, req1_last, req1_ready;
  logic [7:0] req1_x;
  logic [6:0] req1_y;
  logic [2:0] req1_col;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] col_out;
  logic       plot_out;
  logic [1:0] grant;
  logic       clip_pulse, timeout_pulse;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } px_t;

  px_t sb[$];
  int  n_chk  = 0;
  int  n_fail = 0;

  plot_port_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_x(req0_x), .req0_y(req0_y),
    .req0_col(req0_col), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_x(req1_x), .req1_y(req1_y),
    .req1_col(req1_col), .req1_last(req1_last), .req1_ready(req1_ready),
    .x_out(x_out), .y_out(y_out), .col_out(col_out),
    .plot_out(plot_out), .grant(grant),
    .clip_pulse(clip_pulse), .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [7:0] x,
                      input logic [6:0] y, input logic [2:0] c,
                      input logic l);
    req0_valid = v; req0_x = x; req0_y = y; req0_col = c; req0_last = l;
  endtask

  task automatic set1(input logic v, input logic [7:0] x,
                      input logic [6:0] y, input logic [2:0] c,
                      input logic l);
    req1_valid = v; req1_x = x; req1_y = y; req1_col = c; req1_last = l;
  endtask

  task automatic push(input logic [7:0] x, input logic [6:0] y,
                      input logic [2:0] c);
    px_t p;
    p.x = x; p.y = y; p.c = c;
    sb.push_back(p);
  endtask

  task automatic chk_plot(input string tag, input logic exp);
    px_t p;
    chk({tag, "_plot"}, 32'(plot_out), 32'(exp));
    if (exp && sb.size() != 0) begin
      p = sb.pop_front();
      chk({tag, "_x"}, 32'(x_out), 32'(p.x));
      chk({tag, "_y"}, 32'(y_out), 32'(p.y));
      chk({tag, "_col"}, 32'(col_out), 32'(p.c));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    cyc();
    cyc();
    reset = 1'b0;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_plot", 32'(plot_out), 32'h0);
    chk("rst_ready", 32'({req1_ready, req0_ready}), 32'h0);
    chk("rst_xy", 32'({x_out, y_out, col_out}), 32'h0);
    chk("rst_pulses", 32'({clip_pulse, timeout_pulse}), 32'h0);

    // single burst from req0
    set0(1, 10, 5, 1, 0);
    cyc();
    chk("sb_grant", 32'(grant), 32'h1);
    chk("sb_ready0", 32'(req0_ready), 32'h1);
    chk_plot("sb_c0", 0);
    push(10, 5, 1);
    cyc();
    chk_plot("sb_p0", 1);
    set0(1, 11, 5, 2, 0);
    push(11, 5, 2);
    cyc();
    chk_plot("sb_p1", 1);
    set0(1, 12, 5, 3, 1);
    push(12, 5, 3);
    cyc();
    chk_plot("sb_p2", 1);
    chk("sb_release", 32'(grant), 32'h0);
    set0(0, 0, 0, 0, 0);
    cyc();
    chk_plot("sb_end", 0);

    // contention after reset: req0 wins, then req1 despite re-request
    do_reset();
    set0(1, 20, 30, 4, 1);
    set1(1, 40, 50, 5, 1);
    cyc();
    chk("ct_grant0", 32'(grant), 32'h1);
    chk("ct_ready1", 32'(req1_ready), 32'h0);
    push(20, 30, 4);
    cyc();
    chk_plot("ct_p0", 1);
    chk("ct_idle", 32'(grant), 32'h0);
    cyc();
    chk("ct_grant1", 32'(grant), 32'h2);
    chk_plot("ct_c1", 0);
    set0(0, 0, 0, 0, 0);
    push(40, 50, 5);
    cyc();
    chk_plot("ct_p1", 1);
    chk("ct_idle2", 32'(grant), 32'h0);
    set1(0, 0, 0, 0, 0);
    cyc();

    // clipping on req1
    set1(1, 160, 10, 6, 0);
    cyc();
    chk("cl_grant", 32'(grant), 32'h2);
    cyc();
    chk_plot("cl_drop", 0);
    chk("cl_pulse", 32'(clip_pulse), 32'h1);
    chk("cl_hold_x", 32'(x_out), 32'd40);
    set1(1, 159, 119, 7, 1);
    push(159, 119, 7);
    cyc();
    chk_plot("cl_edge", 1);
    chk("cl_pulse_off", 32'(clip_pulse), 32'h0);
    set1(0, 0, 0, 0, 0);
    cyc();

    // watchdog revokes req0, pending req1 granted next
    set0(1, 1, 2, 3, 0);
    cyc();
    chk("wd_grant0", 32'(grant), 32'h1);
    push(1, 2, 3);
    cyc();
    chk_plot("wd_p0", 1);
    set0(0, 0, 0, 0, 0);
    set1(1, 70, 80, 2, 1);
    for (int i = 0; i < 3; i++) cyc();
    chk("wd_hold", 32'(grant), 32'h1);
    chk("wd_no_to", 32'(timeout_pulse), 32'h0);
    cyc();
    chk("wd_to", 32'(timeout_pulse), 32'h1);
    chk("wd_revoked", 32'(grant), 32'h0);
    cyc();
    chk("wd_grant1", 32'(grant), 32'h2);
    chk("wd_to_off", 32'(timeout_pulse), 32'h0);
    push(70, 80, 2);
    cyc();
    chk_plot("wd_p1", 1);
    set1(0, 0, 0, 0, 0);
    cyc();

    // reset in the middle of a req1 burst
    set1(1, 5, 6, 1, 0);
    cyc();
    chk("mr_grant1", 32'(grant), 32'h2);
    push(5, 6, 1);
    cyc();
    chk_plot("mr_p0", 1);
    set1(1, 7, 8, 2, 0);
    reset = 1'b1;
    #1;
    chk("mr_grant", 32'(grant), 32'h0);
    chk("mr_plot", 32'(plot_out), 32'h0);
    chk("mr_xy", 32'({x_out, y_out, col_out}), 32'h0);
    set1(0, 0, 0, 0, 0);
    cyc();
    reset = 1'b0;
    set0(1, 9, 9, 1, 1);
    set1(1, 3, 3, 3, 1);
    cyc();
    chk("mr_tie", 32'(grant), 32'h1);
    chk_plot("mr_c", 0);
    push(9, 9, 1);
    set1(0, 0, 0, 0, 0);
    cyc();
    chk_plot("mr_p1", 1);
    set0(0, 0, 0, 0, 0);
    cyc();

    // stall: valid 1,0,1 with last on the third
    set0(1, 30, 31, 1, 0);
    cyc();
    chk("st_grant", 32'(grant), 32'h1);
    push(30, 31, 1);
    cyc();
    chk_plot("st_p0", 1);
    set0(0, 30, 31, 1, 0);
    cyc();
    chk_plot("st_gap", 0);
    chk("st_keep", 32'(grant), 32'h1);
    set0(1, 32, 33, 2, 1);
    push(32, 33, 2);
    cyc();
    chk_plot("st_p1", 1);
    chk("st_release", 32'(grant), 32'h0);
    set0(0, 0, 0, 0, 0);
    cyc();
    chk_plot("st_end", 0);
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
